// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared encodings for the load/store unit.
//   sl codes      : operation select from EXU (11 is folded onto NONE by the top)
//   funct3 codes  : RISC-V load/store size and sign
//   lsu_state_e   : 2-bit LSU sequencing states
//   size_mask()   : byte-enable pattern for an access size at offset 0
//   misaligned()  : natural-alignment check for an access size
package ysyx_22040895_lsu_pkg;

   localparam int LSU_XLEN = 64;

   localparam logic [1:0] SL_NONE  = 2'b00;
   localparam logic [1:0] SL_LOAD  = 2'b01;
   localparam logic [1:0] SL_STORE = 2'b10;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10,
      ST_WB   = 2'b11
   } lsu_state_e;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
      case (sz)
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = |off[1:0];
         2'b11:   misaligned = |off;
         default: misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Combinational lane logic for the LSU.
//   sl, funct3, off : operation, size/sign and byte offset within the 64-bit word
//   wdata, rdata    : raw store data / aligned read data from the bus
//   err             : misaligned access or illegal size for the operation
//   wmask, wdata_sh : store byte enables and lane-shifted store data (0 mask for non-stores)
//   rdata_ext       : read data shifted down to bit 0 and sign/zero extended
module ysyx_22040895_lsu_align
   import ysyx_22040895_lsu_pkg::*;
#(
   parameter int XLEN = LSU_XLEN
) (
   input  logic [1:0]      sl,
   input  logic [2:0]      funct3,
   input  logic [2:0]      off,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic            err,
   output logic [7:0]      wmask,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] rdata_ext
);

   logic [5:0]      sh;
   logic [XLEN-1:0] rsh;

   assign sh       = {off, 3'b000};
   assign wdata_sh = wdata << sh;
   assign rsh      = rdata >> sh;

   always_comb begin
      err   = 1'b0;
      wmask = 8'h00;
      case (sl)
         SL_LOAD:  err = (funct3 == 3'b111) || misaligned(funct3[1:0], off);
         SL_STORE: begin
            err   = funct3[2] || misaligned(funct3[1:0], off);
            wmask = size_mask(funct3[1:0]) << off;
         end
         default:  err = 1'b0;
      endcase
   end

   always_comb begin
      rdata_ext = rsh;
      case (funct3)
         F3_B:    rdata_ext = {{(XLEN-8){rsh[7]}}, rsh[7:0]};
         F3_H:    rdata_ext = {{(XLEN-16){rsh[15]}}, rsh[15:0]};
         F3_W:    rdata_ext = {{(XLEN-32){rsh[31]}}, rsh[31:0]};
         F3_BU:   rdata_ext = {{(XLEN-8){1'b0}}, rsh[7:0]};
         F3_HU:   rdata_ext = {{(XLEN-16){1'b0}}, rsh[15:0]};
         F3_WU:   rdata_ext = {{(XLEN-32){1'b0}}, rsh[31:0]};
         default: rdata_ext = rsh;
      endcase
   end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: accepts one EXU op, runs at most one 64-bit bus transaction,
// then emits a single write-back beat.
//   valid_i_lsu/ready_o_lsu     : EXU handshake
//   sl/funct3/addr/wdata/rd     : operation fields from EXU
//   mem_req_* / mem_rsp_*       : aligned request/response bus
//   wb_*                        : one-cycle register write-back pulse
//   err_o                       : misaligned/illegal/timed-out access, valid with wb_valid_o
//
// state   | meaning
// IDLE    | ready for a new op
// REQ     | request driven, waiting for mem_req_ready_i
// RESP    | waiting for read data / write ack
// WB      | write-back pulse
module ysyx_22040895_lsu
   import ysyx_22040895_lsu_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int XLEN    = LSU_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i_lsu,
   output logic            ready_o_lsu,
   input  logic [1:0]      sl_i_lsu,
   input  logic [2:0]      funct3_i_lsu,
   input  logic [XLEN-1:0] addr_i_lsu,
   input  logic [XLEN-1:0] wdata_i_lsu,
   input  logic [4:0]      rd_i_lsu,
   output logic            mem_req_valid_o,
   input  logic            mem_req_ready_i,
   output logic [XLEN-1:0] mem_addr_o,
   output logic            mem_wen_o,
   output logic [7:0]      mem_wmask_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_rsp_valid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            wb_valid_o,
   output logic            wb_wen_o,
   output logic [4:0]      wb_rd_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic            err_o
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

   lsu_state_e      state;
   logic [1:0]      sl_q;
   logic [2:0]      f3_q;
   logic [2:0]      off_q;
   logic [31:0]     cnt;

   logic [1:0]      sl_n;
   logic            use_in;
   logic [1:0]      a_sl;
   logic [2:0]      a_f3;
   logic [2:0]      a_off;
   logic            a_err;
   logic [7:0]      a_wmask;
   logic [XLEN-1:0] a_wdata;
   logic [XLEN-1:0] a_rdata;
   logic            timeout_hit;

   assign sl_n   = (sl_i_lsu == 2'b11) ? SL_NONE : sl_i_lsu;
   // Decode straight from the EXU inputs while idle, from the held op otherwise.
   assign use_in = (state == ST_IDLE);
   assign a_sl   = use_in ? sl_n : sl_q;
   assign a_f3   = use_in ? funct3_i_lsu : f3_q;
   assign a_off  = use_in ? addr_i_lsu[2:0] : off_q;

   // cnt holds the number of completed REQ/RESP cycles; the abort fires on the
   // TIMEOUT-th cycle and takes priority over a handshake in that same cycle.
   assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

   ysyx_22040895_lsu_align #(.XLEN(XLEN)) u_align (
      .sl        (a_sl),
      .funct3    (a_f3),
      .off       (a_off),
      .wdata     (wdata_i_lsu),
      .rdata     (mem_rdata_i),
      .err       (a_err),
      .wmask     (a_wmask),
      .wdata_sh  (a_wdata),
      .rdata_ext (a_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         sl_q            <= SL_NONE;
         f3_q            <= 3'b000;
         off_q           <= 3'b000;
         cnt             <= '0;
         ready_o_lsu     <= 1'b1;
         mem_req_valid_o <= 1'b0;
         mem_addr_o      <= '0;
         mem_wen_o       <= 1'b0;
         mem_wmask_o     <= 8'h00;
         mem_wdata_o     <= '0;
         wb_valid_o      <= 1'b0;
         wb_wen_o        <= 1'b0;
         wb_rd_o         <= 5'd0;
         wb_data_o       <= '0;
         err_o           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid_i_lsu && ready_o_lsu) begin
                  sl_q        <= sl_n;
                  f3_q        <= funct3_i_lsu;
                  off_q       <= addr_i_lsu[2:0];
                  wb_rd_o     <= rd_i_lsu;
                  ready_o_lsu <= 1'b0;
                  if (sl_n == SL_NONE) begin
                     state      <= ST_WB;
                     wb_valid_o <= 1'b1;
                     wb_wen_o   <= (rd_i_lsu != 5'd0);
                     wb_data_o  <= addr_i_lsu;
                     err_o      <= 1'b0;
                  end else if (a_err) begin
                     state      <= ST_WB;
                     wb_valid_o <= 1'b1;
                     wb_wen_o   <= 1'b0;
                     wb_data_o  <= '0;
                     err_o      <= 1'b1;
                  end else begin
                     state           <= ST_REQ;
                     cnt             <= '0;
                     mem_req_valid_o <= 1'b1;
                     mem_addr_o      <= {addr_i_lsu[XLEN-1:3], 3'b000};
                     mem_wen_o       <= (sl_n == SL_STORE);
                     mem_wmask_o     <= a_wmask;
                     mem_wdata_o     <= (sl_n == SL_STORE) ? a_wdata : '0;
                  end
               end
            end
            ST_REQ, ST_RESP: begin
               cnt <= cnt + 32'd1;
               if (timeout_hit) begin
                  state           <= ST_WB;
                  mem_req_valid_o <= 1'b0;
                  wb_valid_o      <= 1'b1;
                  wb_wen_o        <= 1'b0;
                  wb_data_o       <= '0;
                  err_o           <= 1'b1;
               end else if (state == ST_REQ) begin
                  if (mem_req_ready_i) begin
                     state           <= ST_RESP;
                     mem_req_valid_o <= 1'b0;
                  end
               end else if (mem_rsp_valid_i) begin
                  state      <= ST_WB;
                  wb_valid_o <= 1'b1;
                  wb_wen_o   <= (sl_q != SL_STORE) && (wb_rd_o != 5'd0);
                  wb_data_o  <= (sl_q == SL_LOAD) ? a_rdata : '0;
                  err_o      <= 1'b0;
               end
            end
            ST_WB: begin
               state       <= ST_IDLE;
               ready_o_lsu <= 1'b1;
               wb_valid_o  <= 1'b0;
               wb_wen_o    <= 1'b0;
               err_o       <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
module tb_ysyx_22040895_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i_lsu;
   logic        ready_o_lsu;
   logic [1:0]  sl_i_lsu;
   logic [2:0]  funct3_i_lsu;
   logic [63:0] addr_i_lsu;
   logic [63:0] wdata_i_lsu;
   logic [4:0]  rd_i_lsu;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [63:0] mem_addr_o;
   logic        mem_wen_o;
   logic [7:0]  mem_wmask_o;
   logic [63:0] mem_wdata_o;
   logic        mem_rsp_valid_i;
   logic [63:0] mem_rdata_i;
   logic        wb_valid_o;
   logic        wb_wen_o;
   logic [4:0]  wb_rd_o;
   logic [63:0] wb_data_o;
   logic        err_o;

   int n_vec = 0;
   int n_mis = 0;

   ysyx_22040895_lsu #(.TIMEOUT(TO), .XLEN(64)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_i_lsu     (valid_i_lsu),
      .ready_o_lsu     (ready_o_lsu),
      .sl_i_lsu        (sl_i_lsu),
      .funct3_i_lsu    (funct3_i_lsu),
      .addr_i_lsu      (addr_i_lsu),
      .wdata_i_lsu     (wdata_i_lsu),
      .rd_i_lsu        (rd_i_lsu),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_addr_o      (mem_addr_o),
      .mem_wen_o       (mem_wen_o),
      .mem_wmask_o     (mem_wmask_o),
      .mem_wdata_o     (mem_wdata_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rdata_i     (mem_rdata_i),
      .wb_valid_o      (wb_valid_o),
      .wb_wen_o        (wb_wen_o),
      .wb_rd_o         (wb_rd_o),
      .wb_data_o       (wb_data_o),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%h want 0x%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference load result: pick the byte lane, keep size bytes, extend.
   function automatic logic [63:0] load_model(input int f3, input int off, input logic [63:0] rdata);
      int          nb;
      logic [63:0] v;
      logic [63:0] m;
      nb = 1 << (f3 % 4);
      v  = rdata >> (8 * off);
      if (nb == 8) return v;
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (f3 < 4 && ((v >> (8 * nb - 1)) & 64'd1) != 64'd0) v = v | ~m;
      return v;
   endfunction

   task automatic run_op(input int sl, input int f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input int rd, input logic [63:0] rdata,
                         input int rw, input int sw, input bit no_rsp);
      int          sl_e, nb, off, done, exp_cyc, req_last, last, seen;
      bit          bad, mem;
      logic        exp_err, exp_wen;
      logic [63:0] exp_data, exp_addr, exp_wd;
      logic [7:0]  exp_mask;

      sl_e = (sl == 3) ? 0 : sl;
      nb   = 1 << (f3 % 4);
      off  = int'(addr % 64'd8);
      bad  = (sl_e == 1 && (f3 == 7 || (off % nb) != 0)) ||
             (sl_e == 2 && (f3 >= 4 || (off % nb) != 0));
      mem  = (sl_e != 0) && !bad;
      done = rw + sw + 2;

      if (!mem) begin
         exp_cyc  = 1;
         exp_err  = bad;
         exp_wen  = !bad && rd != 0;
         exp_data = bad ? 64'd0 : addr;
      end else if (no_rsp || done >= TO) begin
         exp_cyc  = TO + 1;
         exp_err  = 1'b1;
         exp_wen  = 1'b0;
         exp_data = 64'd0;
      end else begin
         exp_cyc  = done + 1;
         exp_err  = 1'b0;
         exp_wen  = (sl_e == 1) && rd != 0;
         exp_data = (sl_e == 1) ? load_model(f3, off, rdata) : 64'd0;
      end
      req_last = mem ? ((rw + 1 < TO) ? rw + 1 : TO) : 0;
      exp_addr = addr & ~64'h7;
      exp_mask = (sl_e == 2) ? 8'((((1 << nb) - 1) << off) & 255) : 8'h00;
      exp_wd   = (sl_e == 2) ? (wdata << (8 * off)) : 64'd0;

      @(negedge clk);
      valid_i_lsu     = 1'b1;
      sl_i_lsu        = 2'(sl);
      funct3_i_lsu    = 3'(f3);
      addr_i_lsu      = addr;
      wdata_i_lsu     = wdata;
      rd_i_lsu        = 5'(rd);
      mem_rdata_i     = rdata;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;

      last = ((exp_cyc > done) ? exp_cyc : done) + 1;
      seen = 0;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         valid_i_lsu = 1'b0;
         chk("req_valid", 64'(mem_req_valid_o), 64'(k <= req_last));
         if (k <= req_last) begin
            chk("mem_addr", mem_addr_o, exp_addr);
            chk("mem_wen", 64'(mem_wen_o), 64'(sl_e == 2));
            chk("mem_wmask", 64'(mem_wmask_o), 64'(exp_mask));
            chk("mem_wdata", mem_wdata_o, exp_wd);
         end
         if (k <= exp_cyc) chk("ready_busy", 64'(ready_o_lsu), 64'd0);
         if (wb_valid_o) begin
            seen++;
            chk("wb_cycle", 64'(k), 64'(exp_cyc));
            chk("wb_err", 64'(err_o), 64'(exp_err));
            chk("wb_wen", 64'(wb_wen_o), 64'(exp_wen));
            chk("wb_rd", 64'(wb_rd_o), 64'(rd));
            chk("wb_data", wb_data_o, exp_data);
         end
         mem_req_ready_i = (k == rw + 1);
         mem_rsp_valid_i = !no_rsp && (k == done);
      end
      chk("wb_count", 64'(seen), 64'd1);
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      chk("ready_idle", 64'(ready_o_lsu), 64'd1);
   endtask

   initial begin
      int          sl, f3, nb, off, rw, sw;
      bit          no_rsp;
      logic [63:0] addr, wdata, rdata;

      rst             = 1'b0;
      valid_i_lsu     = 1'b0;
      sl_i_lsu        = 2'b00;
      funct3_i_lsu    = 3'b000;
      addr_i_lsu      = 64'd0;
      wdata_i_lsu     = 64'd0;
      rd_i_lsu        = 5'd0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rdata_i     = 64'd0;

      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(ready_o_lsu), 64'd1);
      chk("rst_req", 64'(mem_req_valid_o), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_wb_data", wb_data_o, 64'd0);
      chk("rst_mem_addr", mem_addr_o, 64'd0);
      chk("rst_wmask", 64'(mem_wmask_o), 64'd0);
      rst = 1'b1;

      // Directed cases
      run_op(0, 0, 64'h1234, 64'd0, 5, 64'd0, 0, 0, 0);
      run_op(1, 0, 64'h8000_0003, 64'd0, 7, 64'h0000_0000_80FF_0000, 1, 1, 0);
      run_op(1, 4, 64'h8000_0003, 64'd0, 7, 64'h0000_0000_80FF_0000, 0, 1, 0);
      run_op(2, 1, 64'h8000_0006, 64'hABCD, 9, 64'd0, 0, 1, 0);
      run_op(1, 2, 64'h8000_0002, 64'd0, 4, 64'd0, 0, 0, 0);
      run_op(1, 3, 64'h8000_0010, 64'd0, 6, 64'h1, 3, 0, 1);
      run_op(3, 1, 64'hDEAD_BEEF, 64'd0, 0, 64'd0, 0, 0, 0);
      run_op(2, 4, 64'h8000_0000, 64'h55, 2, 64'd0, 0, 0, 0);
      run_op(1, 7, 64'h8000_0000, 64'd0, 2, 64'd0, 0, 0, 0);

      // Reset while waiting for the response; a late response must be ignored.
      @(negedge clk);
      valid_i_lsu  = 1'b1;
      sl_i_lsu     = 2'b01;
      funct3_i_lsu = 3'b011;
      addr_i_lsu   = 64'h8000_0008;
      rd_i_lsu     = 5'd3;
      @(negedge clk);
      valid_i_lsu     = 1'b0;
      mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_req_ready_i = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_mid_ready", 64'(ready_o_lsu), 64'd1);
      chk("rst_mid_req", 64'(mem_req_valid_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem_rsp_valid_i = 1'b1;
      mem_rdata_i     = 64'hFFFF_0000_1111_2222;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mem_rsp_valid_i = 1'b0;
         chk("late_rsp_wb", 64'(wb_valid_o), 64'd0);
         chk("late_rsp_ready", 64'(ready_o_lsu), 64'd1);
      end

      // Randomized ops
      for (int i = 0; i < 80; i++) begin
         sl     = $urandom_range(0, 3);
         f3     = $urandom_range(0, 7);
         nb     = 1 << (f3 % 4);
         off    = $urandom_range(0, 7);
         if ($urandom_range(0, 2) != 0) off = off & ~(nb - 1);
         addr   = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FF8)} | 64'(off);
         if (sl == 0 && $urandom_range(0, 1) == 1) addr = {$urandom, $urandom};
         wdata  = {$urandom, $urandom};
         rdata  = {$urandom, $urandom};
         rw     = $urandom_range(0, 2);
         sw     = $urandom_range(0, 2);
         no_rsp = ($urandom_range(0, 9) == 0);
         run_op(sl, f3, addr, wdata, $urandom_range(0, 31), rdata, rw, sw, no_rsp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
